apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, the APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, the APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, the ACCESS-phase cycle limit (range 1..65535).
REQ-004 SHALL have port clk_i  input  1  single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports req_valid_i input 1, req_ready_o output 1: request handshake.
REQ-007 SHALL have ports req_write_i input 1, req_addr_i input APB_ADDR_WIDTH, req_wdata_i input APB_DATA_WIDTH: request payload.
REQ-008 SHALL have ports resp_valid_o output 1, resp_ready_i input 1: response handshake.
REQ-009 SHALL have ports resp_rdata_o output APB_DATA_WIDTH, resp_err_o output 1: response payload.
REQ-010 SHALL have APB master ports psel_o, penable_o, pwrite_o (output 1), paddr_o (output APB_ADDR_WIDTH), pwdata_o (output APB_DATA_WIDTH), prdata_i (input APB_DATA_WIDTH), pready_i, pslverr_i (input 1); these feed the single slave port of the APB node.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-012 SHALL assert req_ready_o only in IDLE; a request is accepted on a clock edge where req_valid_i and req_ready_o are both 1.
REQ-013 SHALL register write, addr and wdata on acceptance and move IDLE->SETUP.
REQ-014 SETUP: psel_o=1, penable_o=0, lasting exactly one cycle, then ->ACCESS.
REQ-015 ACCESS: psel_o=1, penable_o=1; remains in ACCESS while pready_i=0.
REQ-016 SHALL hold paddr_o, pwrite_o and pwdata_o stable from SETUP through the final ACCESS cycle; all APB outputs SHALL be 0 in IDLE and RESP.
REQ-017 On an ACCESS cycle with pready_i=1: capture pslverr_i into resp_err_o; capture prdata_i into resp_rdata_o for reads, 0 for writes; ->RESP.
REQ-018 RESP: resp_valid_o=1, payload stable until resp_ready_i=1, then ->IDLE.
REQ-019 Minimum latency: accept at edge N; SETUP during cycle N+1; ACCESS during N+2; resp_valid_o high in cycle N+3 when pready_i=1 on the first ACCESS cycle.
REQ-020 SHALL NOT accept a new request while a transfer or response is outstanding; at most one transaction in flight.
REQ-021 resp_rdata_o and resp_err_o SHALL be 0 whenever resp_valid_o=0.
REQ-022 Changes on req_* inputs after acceptance SHALL NOT affect the transfer in flight.

Reset
REQ-023 Asserting rst_ni low SHALL immediately force state IDLE and all outputs to 0 (req_ready_o=0), including mid-SETUP/ACCESS/RESP; the interrupted transaction is discarded and no response is produced.
REQ-024 req_ready_o SHALL rise in the first cycle after rst_ni deasserts.

Configuration
REQ-025 Macro APB_MASTER_BRIDGE_TIMEOUT_EN, when defined, SHALL add a counter of ACCESS cycles, cleared on entry to SETUP.
REQ-026 With the macro defined: if TIMEOUT_CYCLES ACCESS cycles elapse with pready_i=0, then ->RESP with resp_err_o=1 and resp_rdata_o=0; pready_i=1 in the limiting cycle SHALL take precedence (normal completion).
REQ-027 Without the macro: no counter SHALL be present, and ACCESS waits indefinitely for pready_i.

Verification
REQ-028 Read, pready_i=1 immediately, prdata_i=0xDEADBEEF, addr 0x1A10_0004 -> SETUP/ACCESS each 1 cycle with paddr_o=0x1A10_0004; resp_rdata_o=0xDEADBEEF, resp_err_o=0 at N+3.
REQ-029 Write 0x0000_00A5 to 0x1A10_1000, pready_i delayed 3 cycles -> ACCESS lasts 4 cycles with pwdata_o stable; resp_rdata_o=0, resp_err_o=0.
REQ-030 Read with pslverr_i=1 on completion -> resp_err_o=1; resp_ready_i held 0 for 5 cycles -> response stable, req_ready_o=0 throughout.
REQ-031 Timeout macro defined, TIMEOUT_CYCLES=4, pready_i=0 always -> exit after 4 ACCESS cycles, resp_err_o=1, resp_rdata_o=0; repeat with pready_i=1 on cycle 4 -> normal completion.
REQ-032 rst_ni pulled low during ACCESS -> psel_o, penable_o and resp_valid_o are 0 in the same cycle; no response after release; next request completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready request into one APB transfer and
// returns the result on a valid/ready response channel.
// One transaction is in flight at a time.
// Optional feature: define APB_MASTER_BRIDGE_TIMEOUT_EN to bound the ACCESS
// phase to TIMEOUT_CYCLES cycles. A timed-out transfer reports an error.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; all APB outputs are low
// SETUP  | APB setup phase (psel=1, penable=0), lasts one cycle
// ACCESS | APB access phase (psel=1, penable=1), waits for pready
// RESP   | response presented, held until resp_ready_i
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] resp_rdata_o,
    output logic                      resp_err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      write_q, write_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    // Low during reset and for the cycle in which reset is released, so
    // req_ready_o stays low in reset and rises on the first clock after it.
    logic                      out_en_q, out_en_d;
    logic                      apb_active;

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    // State and transaction registers; async reset discards any transfer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            out_en_q <= 1'b0;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            out_en_q <= out_en_d;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    // Next-state logic, request capture and response capture.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        out_en_d = 1'b1;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && out_en_q) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = SETUP;
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    err_d   = pslverr_i;
                    rdata_d = write_q ? '0 : prdata_i;
                    state_d = RESP;
                end
`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign apb_active   = (state_q == SETUP) || (state_q == ACCESS);
    assign req_ready_o  = (state_q == IDLE) && out_en_q;
    assign psel_o       = apb_active;
    assign penable_o    = (state_q == ACCESS);
    assign pwrite_o     = apb_active && write_q;
    assign paddr_o      = apb_active ? addr_q : '0;
    assign pwdata_o     = apb_active ? wdata_q : '0;
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
    assign resp_err_o   = resp_valid_o && err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT_CYCLES = 4).
module tb_apb_master_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o, pwdata_o, prdata_i;
    logic        pready_i, pslverr_i;

    int checks = 0;
    int errors = 0;
    int n_access;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
        .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        tick();
        req_valid_i = 1'b0;
        req_write_i = ~wr;
        req_addr_i  = 32'hFFFF_FFFF;
        req_wdata_i = 32'h1234_5678;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        resp_ready_i = 1'b0; prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
        #2;
        check("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
        check("rst_psel", {31'd0, psel_o}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        tick(); tick();
        rst_ni = 1'b1;
        #1;
        check("rel_ready_low", {31'd0, req_ready_o}, 32'd0);
        tick();
        check("rel_ready_high", {31'd0, req_ready_o}, 32'd1);

        // Read, immediate pready
        pready_i = 1'b1; prdata_i = 32'hDEAD_BEEF;
        request(1'b0, 32'h1A10_0004, 32'h0);
        check("rd_setup_psel", {30'd0, psel_o, penable_o}, 32'd2);
        check("rd_setup_paddr", paddr_o, 32'h1A10_0004);
        check("rd_setup_ready", {31'd0, req_ready_o}, 32'd0);
        tick();
        check("rd_access_psel", {30'd0, psel_o, penable_o}, 32'd3);
        check("rd_access_paddr", paddr_o, 32'h1A10_0004);
        check("rd_access_pwrite", {31'd0, pwrite_o}, 32'd0);
        tick();
        pready_i = 1'b0; prdata_i = 32'h0BAD_0BAD;
        check("rd_resp_valid", {31'd0, resp_valid_o}, 32'd1);
        check("rd_resp_rdata", resp_rdata_o, 32'hDEAD_BEEF);
        check("rd_resp_err", {31'd0, resp_err_o}, 32'd0);
        check("rd_resp_apb", {30'd0, psel_o, penable_o}, 32'd0);
        check("rd_resp_paddr", paddr_o, 32'd0);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("rd_idle_valid", {31'd0, resp_valid_o}, 32'd0);
        check("rd_idle_rdata", resp_rdata_o, 32'd0);
        check("rd_idle_ready", {31'd0, req_ready_o}, 32'd1);

        // Write, pready after 3 wait cycles
        prdata_i = 32'hCAFE_F00D;
        request(1'b1, 32'h1A10_1000, 32'h0000_00A5);
        check("wr_setup_pwdata", pwdata_o, 32'h0000_00A5);
        check("wr_setup_pwrite", {31'd0, pwrite_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr_access_en", {30'd0, psel_o, penable_o}, 32'd3);
            check("wr_access_pwdata", pwdata_o, 32'h0000_00A5);
            check("wr_access_paddr", paddr_o, 32'h1A10_1000);
            pready_i = (i == 3);
        end
        tick();
        pready_i = 1'b0;
        check("wr_resp_valid", {31'd0, resp_valid_o}, 32'd1);
        check("wr_resp_rdata", resp_rdata_o, 32'd0);
        check("wr_resp_err", {31'd0, resp_err_o}, 32'd0);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;

        // Read with slave error, response back-pressured
        pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'h5555_AAAA;
        request(1'b0, 32'h0000_0010, 32'h0);
        tick();
        tick();
        pready_i = 1'b0; pslverr_i = 1'b0;
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("err_resp_valid", {31'd0, resp_valid_o}, 32'd1);
            check("err_resp_err", {31'd0, resp_err_o}, 32'd1);
            check("err_resp_rdata", resp_rdata_o, 32'h5555_AAAA);
            check("err_req_ready", {31'd0, req_ready_o}, 32'd0);
            check("err_no_psel", {31'd0, psel_o}, 32'd0);
            tick();
        end
        req_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("err_idle_err", {31'd0, resp_err_o}, 32'd0);
        check("err_idle_ready", {31'd0, req_ready_o}, 32'd1);

`ifdef APB_MASTER_BRIDGE_TIMEOUT_EN
        // Timeout: pready never comes
        prdata_i = 32'h7777_7777;
        request(1'b0, 32'h0000_0020, 32'h0);
        tick();
        n_access = 0;
        while (penable_o && n_access < 20) begin
            n_access++;
            tick();
        end
        check("to_access_cycles", n_access, 32'd4);
        check("to_resp_valid", {31'd0, resp_valid_o}, 32'd1);
        check("to_resp_err", {31'd0, resp_err_o}, 32'd1);
        check("to_resp_rdata", resp_rdata_o, 32'd0);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;

        // pready in the limiting cycle wins
        request(1'b0, 32'h0000_0024, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tl_access_en", {31'd0, penable_o}, 32'd1);
            pready_i = (i == 3);
        end
        tick();
        pready_i = 1'b0;
        check("tl_resp_valid", {31'd0, resp_valid_o}, 32'd1);
        check("tl_resp_err", {31'd0, resp_err_o}, 32'd0);
        check("tl_resp_rdata", resp_rdata_o, 32'h7777_7777);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
`else
        // Without the timeout, ACCESS waits well past TIMEOUT_CYCLES
        prdata_i = 32'h7777_7777;
        request(1'b0, 32'h0000_0020, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        check("nt_still_access", {30'd0, psel_o, penable_o}, 32'd3);
        check("nt_no_resp", {31'd0, resp_valid_o}, 32'd0);
        pready_i = 1'b1;
        tick();
        pready_i = 1'b0;
        check("nt_resp_valid", {31'd0, resp_valid_o}, 32'd1);
        check("nt_resp_err", {31'd0, resp_err_o}, 32'd0);
        check("nt_resp_rdata", resp_rdata_o, 32'h7777_7777);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
`endif

        // Reset during ACCESS
        request(1'b1, 32'h0000_0030, 32'h0000_0099);
        tick();
        check("rs_in_access", {31'd0, penable_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rs_psel", {31'd0, psel_o}, 32'd0);
        check("rs_penable", {31'd0, penable_o}, 32'd0);
        check("rs_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        check("rs_req_ready", {31'd0, req_ready_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        pready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_no_resp", {31'd0, resp_valid_o}, 32'd0);
            check("rs_no_psel", {31'd0, psel_o}, 32'd0);
        end
        check("rs_ready_back", {31'd0, req_ready_o}, 32'd1);
        prdata_i = 32'h0000_BEEF;
        request(1'b0, 32'h0000_0040, 32'h0);
        tick();
        tick();
        pready_i = 1'b0;
        check("rs_next_valid", {31'd0, resp_valid_o}, 32'd1);
        check("rs_next_rdata", resp_rdata_o, 32'h0000_BEEF);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("rs_next_idle", {31'd0, req_ready_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
